// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the register-file responder.
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ZERO_REG = 31;
    localparam int unsigned ADDR_W   = 5;

    typedef logic [ADDR_W-1:0]               reg_addr_t;
    typedef logic [DATA_W-1:0]               reg_data_t;
    typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_file_t;

    // True for an index that is backed by storage (in range and not the zero register).
    function automatic logic reg_live(input reg_addr_t addr);
        return (32'(addr) < NUM_REGS) && (32'(addr) != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_read_sel.sv
// One read operand: storage mux, zero-register forcing, same-cycle write bypass
// and, with REGFILE_PARITY_EN, the stored-parity check.
module regfile_read_sel
    import regfile_pkg::*;
(
    input  reg_addr_t              addr_i,
    input  reg_file_t              regs_i,
    input  logic                   wr_en_i,
    input  reg_addr_t              wr_addr_i,
    input  reg_data_t              wr_data_i,
`ifdef REGFILE_PARITY_EN
    input  logic [NUM_REGS-1:0]    par_i,
    output logic                   perr_o_c,
`endif
    output reg_data_t              rd_data_o_c
);

    logic live_c;
    logic byp_c;

    always_comb begin
        rd_data_o_c = '0;
`ifdef REGFILE_PARITY_EN
        perr_o_c    = 1'b0;
`endif
        live_c      = reg_live(addr_i);
        byp_c       = live_c && wr_en_i && (wr_addr_i == addr_i);
        if (byp_c) begin
            rd_data_o_c = wr_data_i;
        end else if (live_c) begin
            rd_data_o_c = regs_i[addr_i];
`ifdef REGFILE_PARITY_EN
            perr_o_c    = (^regs_i[addr_i]) != par_i[addr_i];
`endif
        end
    end

endmodule

// File: rtl/regfile_rsp_port.sv
// Register-file responder: 32 x 64-bit storage, two-operand reads through a one-entry
// registered response buffer, one write port. Optional parity under REGFILE_PARITY_EN.
module regfile_rsp_port
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  reg_addr_t  req_addr1,
    input  reg_addr_t  req_addr2,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output reg_data_t  rsp_data1,
    output reg_data_t  rsp_data2,
    input  logic       wr_en,
    input  reg_addr_t  wr_addr,
    input  reg_data_t  wr_data,
    output reg_file_t  reg_out
`ifdef REGFILE_PARITY_EN
    ,
    input  logic       wr_perr_inject,
    output logic [1:0] rsp_perr
`endif
);

    reg_file_t regs_q, regs_d;
    logic      rsp_valid_q, rsp_valid_d;
    reg_data_t data1_q, data1_d;
    reg_data_t data2_q, data2_d;
    reg_data_t sel1_c, sel2_c;
    logic      accept_c;
    logic      wr_live_c;
`ifdef REGFILE_PARITY_EN
    logic [NUM_REGS-1:0] par_q, par_d;
    logic [1:0]          perr_q, perr_d;
    logic [1:0]          sel_perr_c;
`endif

    regfile_read_sel u_sel1 (
        .addr_i      (req_addr1),
        .regs_i      (regs_q),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
`ifdef REGFILE_PARITY_EN
        .par_i       (par_q),
        .perr_o_c    (sel_perr_c[0]),
`endif
        .rd_data_o_c (sel1_c)
    );

    regfile_read_sel u_sel2 (
        .addr_i      (req_addr2),
        .regs_i      (regs_q),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
`ifdef REGFILE_PARITY_EN
        .par_i       (par_q),
        .perr_o_c    (sel_perr_c[1]),
`endif
        .rd_data_o_c (sel2_c)
    );

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept_c  = req_valid && req_ready;
    assign wr_live_c = wr_en && reg_live(wr_addr);

    // Storage update and response buffer: a new accept replaces, a drain alone empties.
    always_comb begin
        regs_d      = regs_q;
        rsp_valid_d = rsp_valid_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
`ifdef REGFILE_PARITY_EN
        par_d       = par_q;
        perr_d      = perr_q;
`endif
        if (wr_live_c) begin
            regs_d[wr_addr] = wr_data;
`ifdef REGFILE_PARITY_EN
            par_d[wr_addr]  = (^wr_data) ^ wr_perr_inject;
`endif
        end
        if (accept_c) begin
            rsp_valid_d = 1'b1;
            data1_d     = sel1_c;
            data2_d     = sel2_c;
`ifdef REGFILE_PARITY_EN
            perr_d      = sel_perr_c;
`endif
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q      <= '0;
            rsp_valid_q <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
`ifdef REGFILE_PARITY_EN
            par_q       <= '0;
            perr_q      <= '0;
`endif
        end else begin
            regs_q      <= regs_d;
            rsp_valid_q <= rsp_valid_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
`ifdef REGFILE_PARITY_EN
            par_q       <= par_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data1 = data1_q;
    assign rsp_data2 = data2_q;
    assign reg_out   = regs_q;
`ifdef REGFILE_PARITY_EN
    assign rsp_perr  = perr_q;
`endif

endmodule
